// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_pkg
// Purpose  : Shared types and helpers for the decode stage: instruction
//            class enum, special opcodes and the opcode-to-class table.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package decode_pkg;

    typedef enum logic [1:0] {
        CLS_N = 2'd0,   // no register traffic (NOP, HALT)
        CLS_R = 2'd1,   // reads rs1/rs2, writes rd
        CLS_I = 2'd2,   // writes rd, carries an immediate
        CLS_S = 2'd3    // reads rd-field and rs1, no write
    } cls_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Widest opcode the class helper accepts; callers zero-extend into it.
    localparam int unsigned OP_MAX_W = 16;

    // Full table for the 4-bit opcode space; other widths fall back to the
    // top two opcode bits (00 N, 01 R, 10 I, 11 S).
    function automatic cls_t op_class(input logic [OP_MAX_W-1:0] op,
                                      input int unsigned         op_w);
        cls_t                c;
        logic [OP_MAX_W-1:0] top;
        c   = CLS_N;
        top = '0;
        if (op_w == 4) begin
            if (op[3:0] == OP_NOP || op[3:0] == OP_HALT) c = CLS_N;
            else if (op[3:0] <= 4'h7)                     c = CLS_R;
            else if (op[3:0] <= 4'hB)                     c = CLS_I;
            else                                          c = CLS_S;
        end else begin
            top = op >> (op_w - 32'd2);
            case (top[1:0])
                2'b00:   c = CLS_N;
                2'b01:   c = CLS_R;
                2'b10:   c = CLS_I;
                default: c = CLS_S;
            endcase
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_if
// Purpose  : Fetch-side, execute-side, writeback and control signals of the
//            decode stage. master = environment (fetch/execute/writeback),
//            slave = the decode stage itself.
// Ports    : none (all signals internal to the interface)
// Revision : 1.0  initial release
// ============================================================================
interface decode_stage_if
    import decode_pkg::*;
#(
    parameter int OP_W      = 4,
    parameter int REG_W     = 4,
    parameter int INSTR_W   = 16,
    parameter int IMM_OUT_W = 16,
    parameter int STALL_W   = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [INSTR_W-1:0]   in_instr;
    logic                 out_valid;
    logic                 out_ready;
    logic [OP_W-1:0]      out_op;
    logic [REG_W-1:0]     out_rd;
    logic [REG_W-1:0]     out_rs1;
    logic [REG_W-1:0]     out_rs2;
    logic [IMM_OUT_W-1:0] out_imm;
    cls_t                 out_class;
    logic                 out_rf_we;
    logic                 out_rf_re;
    logic                 wb_valid;
    logic [REG_W-1:0]     wb_rd;
    logic                 flush;
    logic                 halted;
    logic [STALL_W-1:0]   stall_cnt;

    modport master (
        output in_valid, in_instr, out_ready, wb_valid, wb_rd, flush,
        input  in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_class, out_rf_we, out_rf_re, halted, stall_cnt
    );

    modport slave (
        input  in_valid, in_instr, out_ready, wb_valid, wb_rd, flush,
        output in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_class, out_rf_we, out_rf_re, halted, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Busy bit per architectural register with one set port, two
//            clear ports (writeback, flush) and a hazard query on NQ regs.
// Ports    : clk, rst_n           clock / async active-low reset
//            i_set_en/i_set_reg   mark a register busy (wins over clears)
//            i_wb_clr_en/_reg     writeback clear; also masks the query
//            i_fl_clr_en/_reg     flush clear of a dropped entry
//            i_q_en/i_q_reg       query enables and register addresses
//            o_hazard             any enabled query hits a busy register
// Revision : 1.0  initial release
// ============================================================================
module reg_scoreboard #(
    parameter int REG_W = 4,
    parameter int NQ    = 3
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      i_set_en,
    input  wire logic [REG_W-1:0]          i_set_reg,
    input  wire logic                      i_wb_clr_en,
    input  wire logic [REG_W-1:0]          i_wb_clr_reg,
    input  wire logic                      i_fl_clr_en,
    input  wire logic [REG_W-1:0]          i_fl_clr_reg,
    input  wire logic [NQ-1:0]             i_q_en,
    input  wire logic [NQ-1:0][REG_W-1:0]  i_q_reg,
    output logic                           o_hazard
);
    localparam int NREG = 2**REG_W;
    // Register 0 is hard-wired and can never be busy.
    localparam logic [NREG-1:0] c_r0_mask = {{(NREG-1){1'b1}}, 1'b0};

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set_vec;
    logic [NREG-1:0] w_wb_clr_vec;
    logic [NREG-1:0] w_fl_clr_vec;
    logic [NQ-1:0]   w_hit;

    always_comb begin
        w_set_vec    = '0;
        w_wb_clr_vec = '0;
        w_fl_clr_vec = '0;
        if (i_set_en)    w_set_vec[i_set_reg]       = 1'b1;
        if (i_wb_clr_en) w_wb_clr_vec[i_wb_clr_reg] = 1'b1;
        if (i_fl_clr_en) w_fl_clr_vec[i_fl_clr_reg] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~(w_wb_clr_vec | w_fl_clr_vec)) | w_set_vec)
                      & c_r0_mask;
        end
    end

    // A same-cycle writeback unblocks the query, so issue can proceed
    // in the very cycle the producer retires.
    for (genvar g = 0; g < NQ; g++) begin : g_query
        assign w_hit[g] = i_q_en[g] & r_busy[i_q_reg[g]]
                          & ~w_wb_clr_vec[i_q_reg[g]];
    end

    assign o_hazard = |w_hit;

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : Instruction decode pipeline stage. Splits the instruction into
//            fields, classifies the opcode, blocks issue on RAW/WAW hazards
//            and presents the decoded result one cycle after acceptance.
// Ports    : clk, rst_n   clock / async active-low reset
//            bus (slave)  fetch handshake, decoded output handshake,
//                         writeback, flush, halted, stall_cnt
// Revision : 1.0  initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int OP_W      = 4,
    parameter int REG_W     = 4,
    parameter int INSTR_W   = 16,
    parameter int IMM_OUT_W = 16,
    parameter int STALL_W   = 16
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    decode_stage_if.slave bus
);
    if (INSTR_W != OP_W + 3*REG_W) begin : g_chk_instr_w
        $error("decode_stage: INSTR_W must equal OP_W + 3*REG_W");
    end
    if (IMM_OUT_W < 2*REG_W) begin : g_chk_imm_w
        $error("decode_stage: IMM_OUT_W must be >= 2*REG_W");
    end
    if (OP_W < 2 || OP_W > OP_MAX_W) begin : g_chk_op_w
        $error("decode_stage: OP_W out of supported range");
    end

    // ---------------- field extraction and classification ----------------
    logic [OP_W-1:0]      w_op;
    logic [REG_W-1:0]     w_rd, w_rs1, w_rs2;
    cls_t                 w_cls;
    logic                 w_rf_we, w_rf_re, w_is_halt;
    logic [IMM_OUT_W-1:0] w_imm;

    assign w_op    = bus.in_instr[INSTR_W-1 -: OP_W];
    assign w_rd    = bus.in_instr[3*REG_W-1 -: REG_W];
    assign w_rs1   = bus.in_instr[2*REG_W-1 -: REG_W];
    assign w_rs2   = bus.in_instr[REG_W-1:0];
    assign w_cls   = op_class(OP_MAX_W'(w_op), OP_W);
    assign w_rf_we = (w_cls == CLS_R || w_cls == CLS_I) && (w_rd != '0);
    assign w_rf_re = (w_cls == CLS_R || w_cls == CLS_S);
    assign w_imm   = (w_cls == CLS_I)
                   ? IMM_OUT_W'($signed(bus.in_instr[2*REG_W-1:0])) : '0;
    // HALT is the all-ones opcode at every opcode width.
    assign w_is_halt = (OP_W == 4) ? (w_op == OP_W'(OP_HALT)) : (&w_op);

    // ---------------- hazard scoreboard ----------------
    // Query slots: 0 = rs1, 1 = rs2 (R) or rd-field (S), 2 = written rd.
    logic [2:0]            w_q_en;
    logic [2:0][REG_W-1:0] w_q_reg;
    logic                  w_hazard;
    logic                  w_in_ready, w_accept;

    logic                  r_out_valid, r_out_rf_we, r_out_rf_re, r_halted;
    logic [OP_W-1:0]       r_out_op;
    logic [REG_W-1:0]      r_out_rd, r_out_rs1, r_out_rs2;
    logic [IMM_OUT_W-1:0]  r_out_imm;
    cls_t                  r_out_class;
    logic [STALL_W-1:0]    r_stall_cnt;

    assign w_q_en  = {w_rf_we, w_rf_re, w_rf_re};
    assign w_q_reg = {w_rd, (w_cls == CLS_R) ? w_rs2 : w_rd, w_rs1};

    reg_scoreboard #(
        .REG_W (REG_W),
        .NQ    (3)
    ) u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_set_en     (w_accept && w_rf_we),
        .i_set_reg    (w_rd),
        .i_wb_clr_en  (bus.wb_valid),
        .i_wb_clr_reg (bus.wb_rd),
        .i_fl_clr_en  (bus.flush && r_out_valid && r_out_rf_we),
        .i_fl_clr_reg (r_out_rd),
        .i_q_en       (w_q_en),
        .i_q_reg      (w_q_reg),
        .o_hazard     (w_hazard)
    );

    // ---------------- handshake ----------------
    // rst_n gates in_ready so nothing looks acceptable during reset.
    assign w_in_ready = rst_n && !bus.flush && !r_halted && !w_hazard &&
                        (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // ---------------- output register, halt, stall counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_op    <= '0;
            r_out_rd    <= '0;
            r_out_rs1   <= '0;
            r_out_rs2   <= '0;
            r_out_imm   <= '0;
            r_out_class <= CLS_N;
            r_out_rf_we <= 1'b0;
            r_out_rf_re <= 1'b0;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (bus.flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_op    <= w_op;
                r_out_rd    <= w_rd;
                r_out_rs1   <= w_rs1;
                r_out_rs2   <= w_rs2;
                r_out_imm   <= w_imm;
                r_out_class <= w_cls;
                r_out_rf_we <= w_rf_we;
                r_out_rf_re <= w_rf_re;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (bus.flush)                   r_halted <= 1'b0;
            else if (w_accept && w_is_halt)  r_halted <= 1'b1;

            if (bus.in_valid && w_hazard && !r_halted && !bus.flush &&
                (r_stall_cnt != {STALL_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_op    = r_out_op;
    assign bus.out_rd    = r_out_rd;
    assign bus.out_rs1   = r_out_rs1;
    assign bus.out_rs2   = r_out_rs2;
    assign bus.out_imm   = r_out_imm;
    assign bus.out_class = r_out_class;
    assign bus.out_rf_we = r_out_rf_we;
    assign bus.out_rf_re = r_out_rf_re;
    assign bus.halted    = r_halted;
    assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Parametrised instruction-decode pipeline stage between fetch and execute. It splits the instruction word into opcode, register and immediate fields, and classifies the opcode. A scoreboard blocks issue on RAW and WAW hazards, and a valid/ready handshake runs on both sides. The output register gives one cycle of latency, and a saturating counter records hazard stall cycles.

Parameters:
OP_W, 4, opcode field width
REG_W, 4, register address field width; register file has 2**REG_W entries
INSTR_W, 16, instruction width; must equal OP_W + 3*REG_W (elaboration error otherwise)
IMM_OUT_W, 16, sign-extended immediate output width; must be >= 2*REG_W
STALL_W, 16, stall counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  INSTR_W  instruction word
out_valid  out  1  decoded instruction held for execute
out_ready  in  1  execute consumes output this cycle
out_op  out  OP_W  opcode = instr[INSTR_W-1 -: OP_W]
out_rd  out  REG_W  instr[3*REG_W-1 -: REG_W]
out_rs1  out  REG_W  instr[2*REG_W-1 -: REG_W]
out_rs2  out  REG_W  instr[REG_W-1:0]
out_imm  out  IMM_OUT_W  instr[2*REG_W-1:0] sign-extended; zero unless class I
out_class  out  2  instruction class (package enum)
out_rf_we  out  1  instruction writes rd (class R/I and rd != 0)
out_rf_re  out  1  instruction reads register file (class R/S)
wb_valid  in  1  writeback retires a register write
wb_rd  in  REG_W  register being written back
flush  in  1  discard held output, clear halt
halted  out  1  HALT issued; stage stops accepting
stall_cnt  out  STALL_W  saturating hazard-stall cycle count

Behaviour:
- Reset (async, rst_n=0): out_valid=0; all out_* fields=0; busy[]=0; halted=0; stall_cnt=0. in_ready=0 while in reset.
- Classes (package table, selected on opcode):
  - 0x0 NOP, class N: reads and writes nothing.
  - 0x1-0x7 class R: reads rs1 and rs2, writes rd.
  - 0x8-0xB class I: writes rd, uses imm.
  - 0xC-0xE class S: reads rd-field and rs1, no write.
  - 0xF HALT, class N.
  - For OP_W != 4, the package selects class from the top two opcode bits.
- Hazard (combinational on in_instr):
  - hazard = any source or writing dest of in_instr has busy & ~clr, where clr = wb_valid ? onehot(wb_rd) : 0. Writeback in the same cycle therefore unblocks.
  - Register 0 is never busy.
- in_ready = !flush && !halted && !hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready): fields latched into the output register next edge, out_valid=1. Latency exactly 1 cycle; back-to-back issue at 1/cycle when there are no hazards.
- Busy bits:
  - On accept with out_rf_we, busy[rd] is set.
  - On wb_valid, busy[wb_rd] is cleared.
  - Set and clear of the same register in one cycle: set wins.
  - wb_valid for rd=0 or a non-busy register: no effect.
- Output hold: while out_valid && !out_ready, all out_* are stable.
- out_valid deasserts after a consume with no new accept.
- HALT: accepting opcode 0xF sets halted next edge. HALT itself is issued to execute normally. in_ready stays 0 until flush or reset.
- flush:
  - Next edge: out_valid=0 and halted=0.
  - If the dropped entry had out_rf_we, its busy[out_rd] is cleared. This clear is ORed with the wb clear; flush takes priority over a same-cycle consume.
  - No accept occurs in the flush cycle.
- stall_cnt: increments each cycle in_valid && hazard && !halted && !flush; saturates at all-ones; never wraps.
- rst_n asserted mid-operation: immediate return to reset values; any in-flight output is lost.

Decomposition:
- Package decode_pkg holds:
  - class enum CLS_N/CLS_R/CLS_I/CLS_S;
  - opcode constants OP_NOP, OP_HALT;
  - function op_class(op).
- Sub-module reg_scoreboard (busy vector, set/clear ports, hazard query for up to three registers) instantiated once; decode field extraction stays in decode_stage.

Test Plan:
- Reset then in_instr=0x1234 (R, rd=2, rs1=3, rs2=4) with out_ready=1 -> next cycle out_valid=1, out_op=1, out_rd=2, out_rs1=3, out_rs2=4, out_rf_we=1, out_imm=0; busy[2]=1.
- 0x1234 then 0x2520 (reads r2) with no writeback -> in_ready=0; stall_cnt increments each cycle; assert wb_valid with wb_rd=2 -> accepted that same cycle.
- 0x83F0 (I, rd=3, imm=0xF0) -> out_imm=0xFFF0, out_rf_re=0; 0x8070 -> out_imm=0x0070.
- out_ready=0 for 5 cycles after accept -> outputs stable, in_ready=0; out_ready=1 plus new in_valid -> back-to-back transfer, no bubble.
- 0xF000 accepted -> halted=1, in_ready=0 with in_valid held; flush -> halted=0, out_valid=0, busy bit of a dropped R entry cleared.
- Hold hazard for 2**STALL_W+3 cycles (STALL_W=4 instance) -> stall_cnt=0xF, no wrap; rst_n low mid-hold -> all outputs 0 immediately.
